// File: rtl/join_pipe_multi.sv
// -----------------------------------------------------------------------------
// join_pipe_multi
//
// N-channel fixed-point join stage for the Euler module. Collects one value
// from every channel, adds them, multiplies the sum by the step size h with an
// iterative radix-2 signed multiplier, and writes the product to the result RAM
// at an auto-incrementing, wrapping address.
//
// Sequence: COLLECT -> SUM (1 cycle) -> MUL (DATA_SIZE cycles) -> WRITE (1 cycle).
// With the last capture in cycle T, finished is asserted in cycle T+2+DATA_SIZE.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   clear          synchronous active-high soft clear (same effect as reset)
//   ch_valid       per-channel data valid
//   ch_data        channel i at bits [i*DATA_SIZE +: DATA_SIZE]
//   ch_ready       per-channel ready (~captured in COLLECT, 0 otherwise)
//   h_step         step size, latched at the end of SUM
//   join_done      pulse during the cycle of the last channel transfer
//   busy           high in SUM, MUL and WRITE
//   mem_we         RAM write enable (RAM samples on the falling edge)
//   mem_addr       RAM write address (holds when mem_we=0)
//   mem_data       RAM write data (holds when mem_we=0)
//   finished       pulse coincident with mem_we
//   wrapped        pulse with finished on the write to the last slot
//   overflow_flag  sticky sum/product overflow, cleared by rst or clear
//
// Build option:
//   JOIN_SATURATE_EN  when defined, overflowing sums and products clamp to the
//                     most positive / most negative value; otherwise they wrap.
// -----------------------------------------------------------------------------
module join_pipe_multi #(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int NUM_CH    = 2,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*DATA_SIZE-1:0] ch_data,
    output logic [NUM_CH-1:0]           ch_ready,
    input  logic [DATA_SIZE-1:0]        h_step,
    output logic                        join_done,
    output logic                        busy,
    output logic                        mem_we,
    output logic [ADD_SIZE-1:0]         mem_addr,
    output logic [DATA_SIZE-1:0]        mem_data,
    output logic                        finished,
    output logic                        wrapped,
    output logic                        overflow_flag
);

    localparam int W  = DATA_SIZE;
    localparam int SW = W + $clog2(NUM_CH);   // sum width, cannot overflow
    localparam int PW = 2 * W;                // full product width
    localparam int CW = $clog2(W);            // multiplier step counter width

    localparam logic [ADD_SIZE-1:0] FIRST_ADDR = ADD_SIZE'(BASE_ADDR);
    localparam logic [ADD_SIZE-1:0] LAST_ADDR  = ADD_SIZE'(BASE_ADDR + DEPTH - 1);

`ifdef JOIN_SATURATE_EN
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_COLLECT,
        S_SUM,
        S_MUL,
        S_WRITE
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      captured_q, captured_d;
    logic [NUM_CH-1:0]      fire;
    logic signed [W-1:0]    data_q [NUM_CH];
    logic [ADD_SIZE-1:0]    ptr_q;
    logic [ADD_SIZE-1:0]    addr_q;
    logic [W-1:0]           res_q;
    logic                   ovf_q;

    logic signed [PW-1:0]   mcand_q;   // multiplicand, shifted left each step
    logic [W-1:0]           mplr_q;    // multiplier, shifted right each step
    logic signed [PW-1:0]   acc_q;
    logic [CW-1:0]          cnt_q;

    logic                   live;
    logic                   cnt_last;
    logic signed [SW-1:0]   sum_full;
    logic                   sum_ovf;
    logic [W-1:0]           sum_val;
    logic signed [PW-1:0]   term;
    logic signed [PW-1:0]   acc_d;
    logic signed [PW-1:0]   prod_sh;
    logic                   prod_ovf;
    logic [W-1:0]           res_val;

    // Pulses are suppressed in a cycle that is being reset or cleared, so an
    // aborted operation never reaches the RAM.
    assign live     = rst & ~clear;
    assign cnt_last = (cnt_q == CW'(W - 1));

    // ---------------------------------------------------------------------
    // Next-state and handshake logic
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ch_ready   = '0;
        fire       = '0;
        captured_d = captured_q;
        join_done  = 1'b0;
        case (state_q)
            S_COLLECT: begin
                ch_ready   = ~captured_q;
                fire       = ch_valid & ~captured_q;
                captured_d = captured_q | fire;
                // The join completes in the cycle that delivers the last
                // missing channel (possibly several at once).
                if ((&captured_d) && (|fire)) begin
                    join_done = live;
                    state_d   = S_SUM;
                end
            end
            S_SUM:   state_d = S_MUL;
            S_MUL:   if (cnt_last) state_d = S_WRITE;
            S_WRITE: state_d = S_COLLECT;
            default: state_d = S_COLLECT;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sum of captured values with overflow detection
    // ---------------------------------------------------------------------
    always_comb begin
        sum_full = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_full = sum_full + SW'(data_q[i]);
        end
        // Fits in W bits only if the top SW-W+1 bits are all sign copies.
        sum_ovf = (sum_full[SW-1:W-1] != {(SW-W+1){sum_full[SW-1]}});
`ifdef JOIN_SATURATE_EN
        if (sum_ovf) sum_val = sum_full[SW-1] ? MAX_NEG : MAX_POS;
        else         sum_val = sum_full[W-1:0];
`else
        sum_val = sum_full[W-1:0];
`endif
    end

    // ---------------------------------------------------------------------
    // One radix-2 multiplier step. The multiplier's MSB carries weight
    // -2^(W-1), so the final partial product is subtracted.
    // ---------------------------------------------------------------------
    always_comb begin
        term     = mplr_q[0] ? mcand_q : '0;
        acc_d    = cnt_last ? (acc_q - term) : (acc_q + term);
        prod_sh  = acc_d >>> FRAC_BITS;
        prod_ovf = (prod_sh[PW-1:W-1] != {(PW-W+1){prod_sh[PW-1]}});
`ifdef JOIN_SATURATE_EN
        if (prod_ovf) res_val = prod_sh[PW-1] ? MAX_NEG : MAX_POS;
        else          res_val = prod_sh[W-1:0];
`else
        res_val = prod_sh[W-1:0];
`endif
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state_q    <= S_COLLECT;
            captured_q <= '0;
            for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
            ptr_q      <= FIRST_ADDR;
            addr_q     <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_COLLECT: begin
                    captured_q <= captured_d;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (fire[i]) data_q[i] <= ch_data[i*W +: W];
                    end
                end
                S_SUM: begin
                    if (sum_ovf) ovf_q <= 1'b1;
                    mcand_q <= {{W{sum_val[W-1]}}, sum_val};
                    mplr_q  <= h_step;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end
                S_MUL: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q <<< 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        res_q  <= res_val;
                        addr_q <= ptr_q;
                        if (prod_ovf) ovf_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    captured_q <= '0;
                    ptr_q      <= (ptr_q == LAST_ADDR) ? FIRST_ADDR : ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy          = (state_q != S_COLLECT);
    assign mem_we        = live && (state_q == S_WRITE);
    assign finished      = mem_we;
    assign wrapped       = mem_we && (ptr_q == LAST_ADDR);
    assign mem_addr      = addr_q;
    assign mem_data      = res_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_join_pipe_multi.sv
// -----------------------------------------------------------------------------
// tb_join_pipe_multi
//
// Directed bench for join_pipe_multi with NUM_CH=2, DATA_SIZE=16, FRAC_BITS=8,
// BASE_ADDR=0 and DEPTH=4. Expected values are hand-computed fixed-point
// results (8 fractional bits). Covers reset state, simultaneous and staggered
// arrival, latency, sum overflow (wrap or clamp under JOIN_SATURATE_EN),
// address wrap, clear during MUL and reset during WRITE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_join_pipe_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [1:0]  ch_valid;
    logic [31:0] ch_data;
    logic [1:0]  ch_ready;
    logic [15:0] h_step;
    logic        join_done;
    logic        busy;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        finished;
    logic        wrapped;
    logic        overflow_flag;

    int tests = 0;
    int fails = 0;

    join_pipe_multi #(
        .ADD_SIZE  (16),
        .DATA_SIZE (16),
        .FRAC_BITS (8),
        .NUM_CH    (2),
        .BASE_ADDR (0),
        .DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .h_step        (h_step),
        .join_done     (join_done),
        .busy          (busy),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .finished      (finished),
        .wrapped       (wrapped),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present both channels in the same cycle and check join_done for it.
    task automatic launch(input string tag, input logic [15:0] d0,
                          input logic [15:0] d1, input logic [15:0] h);
        ch_data  = {d1, d0};
        h_step   = h;
        ch_valid = 2'b11;
        #1;
        check({tag, "_join_done"}, {31'b0, join_done}, 32'd1);
        tick();
        ch_valid = 2'b00;
    endtask

    // Step until finished; n counts cycles since the last-capture cycle T.
    task automatic wait_finished(input int start, output int n);
        n = start;
        while (finished !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (finished !== 1'b1) check("finish_timeout", {31'b0, finished}, 32'd1);
    endtask

    initial begin
        int n;
        int seen_we;
        logic [15:0] exp_ovf_data;

`ifdef JOIN_SATURATE_EN
        exp_ovf_data = 16'h7FFF;
`else
        exp_ovf_data = 16'hE000;
`endif

        // ---------------- Reset state ----------------
        rst = 1'b0; clear = 1'b0; ch_valid = 2'b00; ch_data = '0; h_step = '0;
        tick();
        tick();
        check("rst_ch_ready", {30'b0, ch_ready}, 32'h3);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_mem_we",   {31'b0, mem_we}, 32'd0);
        check("rst_wrapped",  {31'b0, wrapped}, 32'd0);
        check("rst_ovf",      {31'b0, overflow_flag}, 32'd0);
        check("rst_addr",     {16'b0, mem_addr}, 32'd0);
        check("rst_data",     {16'b0, mem_data}, 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- Basic: 1.0 + 2.0 = 3.0, * 0.5 = 1.5 ----------------
        launch("basic", 16'h0100, 16'h0200, 16'h0080);
        check("basic_ready_low", {30'b0, ch_ready}, 32'h0);
        check("basic_busy",      {31'b0, busy}, 32'd1);
        wait_finished(1, n);
        check("basic_latency",   n, 32'd18);
        check("basic_addr",      {16'b0, mem_addr}, 32'h0000);
        check("basic_data",      {16'b0, mem_data}, 32'h0180);
        check("basic_ovf",       {31'b0, overflow_flag}, 32'd0);
        check("basic_wrapped",   {31'b0, wrapped}, 32'd0);
        tick();
        check("basic_ready_back", {30'b0, ch_ready}, 32'h3);
        check("basic_we_low",     {31'b0, mem_we}, 32'd0);
        check("basic_data_hold",  {16'b0, mem_data}, 32'h0180);

        // ---------------- Staggered: -1.0 then 3.0, * 1.0 = 2.0 ----------------
        h_step   = 16'h0100;
        ch_data  = {16'hFF00, 16'h0000};
        ch_valid = 2'b10;
        #1;
        check("stag_no_join_T", {31'b0, join_done}, 32'd0);
        tick();                                  // cycle T+1
        check("stag_ready_T1", {30'b0, ch_ready}, 32'h1);
        check("stag_idle_T1",  {31'b0, busy}, 32'd0);
        ch_data = {16'h1234, 16'h0000};          // ignored: ch1 already captured
        tick(); tick(); tick();                  // cycle T+4
        check("stag_no_join_T4", {31'b0, join_done}, 32'd0);
        tick();                                  // cycle T+5
        ch_data  = {16'h1234, 16'h0300};
        ch_valid = 2'b11;
        #1;
        check("stag_join_T5", {31'b0, join_done}, 32'd1);
        tick();
        ch_valid = 2'b00;
        wait_finished(1, n);
        check("stag_latency", n, 32'd18);
        check("stag_addr",    {16'b0, mem_addr}, 32'h0001);
        check("stag_data",    {16'b0, mem_data}, 32'h0200);
        tick();

        // ---------------- Overflow: 0x7000 + 0x7000 ----------------
        launch("ovf", 16'h7000, 16'h7000, 16'h0100);
        check("ovf_flag_in_sum", {31'b0, overflow_flag}, 32'd0);
        tick();
        check("ovf_flag_after_sum", {31'b0, overflow_flag}, 32'd1);
        wait_finished(2, n);
        check("ovf_addr", {16'b0, mem_addr}, 32'h0002);
        check("ovf_data", {16'b0, mem_data}, {16'b0, exp_ovf_data});
        tick();
        check("ovf_sticky", {31'b0, overflow_flag}, 32'd1);

        // ---------------- Clear five cycles into MUL ----------------
        launch("clr", 16'h0100, 16'h0100, 16'h0100);
        tick();                                  // MUL cycle 1
        tick(); tick(); tick(); tick();          // MUL cycle 5
        check("clr_busy_in_mul", {31'b0, busy}, 32'd1);
        clear = 1'b1;
        #1;
        check("clr_no_we", {31'b0, mem_we}, 32'd0);
        tick();
        clear = 1'b0;
        check("clr_ready",  {30'b0, ch_ready}, 32'h3);
        check("clr_busy",   {31'b0, busy}, 32'd0);
        check("clr_ovf",    {31'b0, overflow_flag}, 32'd0);
        seen_we = 0;
        for (int i = 0; i < 25; i++) begin
            if (mem_we === 1'b1) seen_we++;
            tick();
        end
        check("clr_no_write_after", seen_we, 32'd0);

        // ---------------- Wrap: five joins with DEPTH=4 ----------------
        for (int j = 0; j < 5; j++) begin
            launch("wrap", 16'(16'h0100 * (j + 1)), 16'h0100, 16'h0100);
            wait_finished(1, n);
            check($sformatf("wrap%0d_addr", j), {16'b0, mem_addr}, j % 4);
            check($sformatf("wrap%0d_data", j), {16'b0, mem_data}, (j + 2) * 256);
            check($sformatf("wrap%0d_wrapped", j), {31'b0, wrapped}, (j == 3) ? 32'd1 : 32'd0);
            tick();
        end

        // ---------------- Reset during WRITE ----------------
        launch("rstw", 16'h0100, 16'h0100, 16'h0100);
        wait_finished(1, n);
        check("rstw_in_write", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstw_finished", {31'b0, finished}, 32'd0);
        check("rstw_busy",     {31'b0, busy}, 32'd0);
        check("rstw_ready",    {30'b0, ch_ready}, 32'h3);
        tick();
        launch("post_rst", 16'h0040, 16'h0040, 16'h0200);   // 0.5 * 2.0 = 1.0
        wait_finished(1, n);
        check("post_rst_addr", {16'b0, mem_addr}, 32'h0000);
        check("post_rst_data", {16'b0, mem_data}, 32'h0100);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
